img_pingpong_buffer: RTL and testbench
======================================

Name: img_pingpong_buffer

Overview:
- Frame-level producer (responder) feeding the im2col engine.
- Accepts a 28x28 8-bit image one row per valid/ready beat into one of two banks.
- Hands a completed frame downstream over a valid/ready handshake, then serves the consumer's row-address requests with a 3-row window until the consumer releases the frame.
- Ping-pong operation lets frame N+1 load while im2col consumes frame N.

Parameters:
IMG_W, 28, pixels per row
IMG_H, 28, rows per frame
K, 3, window height (rows returned per address)
DW, 8, pixel width
AW, 5, row-address width, clog2(IMG_H)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-low reset
i_pre_valid  in  1  upstream row beat valid
o_pre_ready  out  1  buffer can accept a row beat
i_row_data  in  DW x IMG_W  one image row, index 0 = column 0
o_post_valid  out  1  a full frame is ready for hand-off
i_post_ready  in  1  consumer accepts the frame
i_addr  in  AW  top row of the requested window
o_data  out  DW x K x IMG_W  rows i_addr..i_addr+K-1 of the served frame
i_release  in  1  single-cycle pulse, consumer finished with the frame
o_busy  out  1  frame currently owned by the consumer

Behaviour:
- Reset (i_rst low, async): bank full flags = 0, wr_bank = 0, rd_bank = 0, wr_row = 0, read FSM = IDLE.
  - Outputs: o_pre_ready = 1, o_post_valid = 0, o_busy = 0, o_data = 0.
  - Pixel storage is not reset.
  - Reset mid-load discards the partial frame. Reset mid-serve drops the frame.
- Write side:
  - o_pre_ready = !full[wr_bank].
  - Beat accepted when i_pre_valid && o_pre_ready: row wr_row of bank wr_bank <= i_row_data; wr_row++.
  - On the beat with wr_row == IMG_H-1: wr_row <= 0, full[wr_bank] <= 1, wr_bank toggles.
  - Back-to-back beats are allowed at full rate. A frame takes exactly IMG_H accepted beats.
- Read FSM, two states:
  - IDLE: o_post_valid = full[rd_bank], o_busy = 0, o_data = 0. On i_post_ready && o_post_valid -> BUSY.
  - BUSY: o_post_valid = 0, o_busy = 1. o_data is combinational from bank rd_bank: o_data[k] = row (i_addr+k), zero-latency.
    - Any row index >= IMG_H reads as all zeros.
    - i_addr compare is performed in AW+1 bits to avoid wrap.
  - BUSY exit on i_release: full[rd_bank] <= 0, rd_bank toggles, -> IDLE.
  - i_release in IDLE is ignored. i_post_ready without o_post_valid is ignored.
- Latency: o_post_valid rises the cycle after the last row beat is accepted, when that bank is rd_bank and the FSM is IDLE.
  - o_post_valid holds until the hand-off; it only drops via the handshake.
- Both banks full: o_pre_ready = 0 until a release.
  - The cycle after i_release frees a bank, o_pre_ready = 1 (registered flag).
- Simultaneous events:
  - Final write beat into one bank and i_release of the other bank in the same cycle: both take effect.
  - Write and release never target the same bank, by construction.
- Ordering: frames are served strictly in load order. rd_bank never overtakes wr_bank.

Decomposition:
- Package conv_pkg:
  - Constants IMG_W, IMG_H, K, DW.
  - Typedefs pixel_t (logic [DW-1:0]), row_t (pixel_t [IMG_W-1:0]), win_t (row_t [K-1:0]).
  - Enum rd_state_t {RD_IDLE, RD_BUSY}.
- Sub-module img_bank, instantiated twice:
  - IMG_H x row_t register store.
  - One row write port (we, row index, data).
  - Combinational K-row window read with zero-fill beyond IMG_H.
- Top level holds the flags, pointers, FSM and output muxing.

Test Plan:
- Single frame: load 28 rows where row r, column c = r+c (mod 256); handshake; i_addr = 0 -> o_data[0][5] = 5, o_data[2][27] = 29. i_addr = 25 -> o_data[2][0] = 27.
- Boundary: in BUSY, i_addr = 26 -> o_data[2] all zeros; i_addr = 31 -> all three rows zero.
- Ping-pong: load frame A (fill 0xAA); hand off; load frame B (fill 0xBB) while BUSY.
  - After B's 28th beat, o_pre_ready = 0.
  - Release A -> IDLE, o_post_valid = 1 next cycle; serve B -> reads return 0xBB.
  - o_pre_ready = 1 the cycle after the release.
- Simultaneous: B's final beat in the same cycle as A's i_release -> full = {1 for B}, A freed. o_post_valid for B next cycle, o_pre_ready = 1.
- Backpressure/ignored inputs: hold i_post_ready = 0 for 10 cycles -> o_post_valid stays 1. i_release pulse in IDLE -> no state change.
- Reset mid-operation: assert i_rst low after 14 row beats -> immediately o_pre_ready = 1, o_post_valid = 0, o_data = 0. A following 28-beat load yields a correct frame.

Source files
------------

// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared constants and types for the image ping-pong buffer that feeds the
// im2col engine.
//   IMG_W / IMG_H : image geometry (pixels per row / rows per frame)
//   K             : number of rows returned per window read
//   DW            : pixel width
//   AW            : row-address width
//   pixel_t / row_t / win_t : pixel, image row, K-row window
//   rd_state_t    : read-side ownership state
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int K     = 3;
    localparam int DW    = 8;
    localparam int AW    = 5;

    // Row count expressed in the widened (AW+1) index domain.
    localparam logic [AW:0] IMG_H_W = (AW+1)'(IMG_H);
    // Index of the final row of a frame in the row-pointer domain.
    localparam logic [AW-1:0] LAST_ROW = AW'(IMG_H - 1);

    typedef logic [DW-1:0]        pixel_t;
    typedef pixel_t [IMG_W-1:0]   row_t;
    typedef row_t   [K-1:0]       win_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_BUSY = 1'b1
    } rd_state_t;

    // True when a widened row index addresses a real image row.
    function automatic logic row_in_range(input logic [AW:0] idx);
        return (idx < IMG_H_W);
    endfunction

    // One-hot select of bank 0 or bank 1.
    function automatic logic [1:0] bank_onehot(input logic bank);
        return bank ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/img_pingpong_buffer_bank.sv
// -----------------------------------------------------------------------------
// img_bank
// One frame of storage: IMG_H rows of row_t held in registers.
//   i_clk     : clock, rising edge
//   i_we      : write strobe for one row
//   i_wr_row  : row index to write
//   i_wr_data : row contents
//   i_rd_addr : top row of the K-row window
//   o_win     : rows i_rd_addr..i_rd_addr+K-1, zero for rows past the image
// Pixel storage is deliberately not reset; validity is tracked by the parent.
// -----------------------------------------------------------------------------
module img_bank
    import conv_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_wr_row,
    input  row_t          i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output win_t          o_win
);

    row_t        r_mem [IMG_H];
    logic [AW:0] w_idx [K];

    // Row write port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wr_row] <= i_wr_data;
        end
    end

    // Window read; the index is widened by one bit so i_rd_addr+k cannot wrap
    // back into the valid row range.
    always_comb begin
        o_win = '0;
        for (int k = 0; k < K; k++) begin
            w_idx[k] = {1'b0, i_rd_addr} + (AW+1)'(k);
            if (row_in_range(w_idx[k])) begin
                o_win[k] = r_mem[w_idx[k][AW-1:0]];
            end else begin
                o_win[k] = '0;
            end
        end
    end

endmodule

// File: rtl/img_pingpong_buffer.sv
// -----------------------------------------------------------------------------
// img_pingpong_buffer
// Two-bank frame buffer between an upstream row producer and the im2col
// consumer. One bank loads while the other is being served.
//   i_clk, i_rst       : clock (rising edge), async active-low reset
//   i_pre_valid/o_pre_ready, i_row_data : one image row per accepted beat
//   o_post_valid/i_post_ready           : frame hand-off to the consumer
//   i_addr / o_data    : K-row window read from the owned frame (combinational)
//   i_release          : consumer finished with its frame
//   o_busy             : a frame is currently owned by the consumer
// -----------------------------------------------------------------------------
module img_pingpong_buffer
    import conv_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_pre_valid,
    output logic          o_pre_ready,
    input  row_t          i_row_data,
    output logic          o_post_valid,
    input  logic          i_post_ready,
    input  logic [AW-1:0] i_addr,
    output win_t          o_data,
    input  logic          i_release,
    output logic          o_busy
);

    logic [1:0]    r_full;
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [AW-1:0] r_wr_row;
    rd_state_t     r_state;
    rd_state_t     w_state_nxt;

    logic          w_wr_fire;
    logic          w_last_beat;
    logic          w_release;
    logic [1:0]    w_bank_we;
    logic [1:0]    w_full_set;
    logic [1:0]    w_full_clr;
    logic [1:0]    w_full_nxt;
    win_t          w_win [2];

    // The write bank is free whenever its flag is clear; since frames are
    // consumed in order this is only ever false when both banks hold frames.
    assign o_pre_ready = ~r_full[r_wr_bank];
    assign w_wr_fire   = i_pre_valid & o_pre_ready;
    assign w_last_beat = (r_wr_row == LAST_ROW);
    assign w_bank_we   = w_wr_fire ? bank_onehot(r_wr_bank) : 2'b00;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        img_bank u_bank (
            .i_clk     (i_clk),
            .i_we      (w_bank_we[b]),
            .i_wr_row  (r_wr_row),
            .i_wr_data (i_row_data),
            .i_rd_addr (i_addr),
            .o_win     (w_win[b])
        );
    end

    // Read-side FSM: offer a full bank, then serve windows until release.
    always_comb begin
        w_state_nxt  = r_state;
        o_post_valid = 1'b0;
        o_busy       = 1'b0;
        o_data       = '0;
        w_release    = 1'b0;
        case (r_state)
            RD_IDLE: begin
                o_post_valid = r_full[r_rd_bank];
                if (i_post_ready && r_full[r_rd_bank]) begin
                    w_state_nxt = RD_BUSY;
                end else begin
                    w_state_nxt = RD_IDLE;
                end
            end
            RD_BUSY: begin
                o_busy = 1'b1;
                o_data = r_rd_bank ? w_win[1] : w_win[0];
                if (i_release) begin
                    w_release   = 1'b1;
                    w_state_nxt = RD_IDLE;
                end else begin
                    w_state_nxt = RD_BUSY;
                end
            end
            default: begin
                w_state_nxt = RD_IDLE;
            end
        endcase
    end

    // Full-flag update; a frame completion and a release touch different
    // banks, so both may land in the same cycle.
    always_comb begin
        w_full_set = (w_wr_fire & w_last_beat) ? bank_onehot(r_wr_bank) : 2'b00;
        w_full_clr = w_release ? bank_onehot(r_rd_bank) : 2'b00;
        w_full_nxt = (r_full | w_full_set) & ~w_full_clr;
    end

    // State, flags and pointers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_row  <= '0;
            r_state   <= RD_IDLE;
        end else begin
            r_full  <= w_full_nxt;
            r_state <= w_state_nxt;
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end else begin
                r_rd_bank <= r_rd_bank;
            end
            if (w_wr_fire && w_last_beat) begin
                r_wr_row  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else if (w_wr_fire) begin
                r_wr_row  <= r_wr_row + AW'(1);
                r_wr_bank <= r_wr_bank;
            end else begin
                r_wr_row  <= r_wr_row;
                r_wr_bank <= r_wr_bank;
            end
        end
    end

endmodule

// File: tb/tb_img_pingpong_buffer.sv
// -----------------------------------------------------------------------------
// Bench for img_pingpong_buffer: directed sequences with a table of window
// reads, then randomized traffic against a frame-FIFO reference model.
// -----------------------------------------------------------------------------
module tb_img_pingpong_buffer;
    import conv_pkg::*;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_pre_valid = 1'b0;
    logic          i_post_ready = 1'b0;
    logic          i_release = 1'b0;
    logic [AW-1:0] i_addr = '0;
    row_t          i_row_data = '0;
    logic          o_pre_ready;
    logic          o_post_valid;
    logic          o_busy;
    win_t          o_data;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    img_pingpong_buffer dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pre_valid  (i_pre_valid),
        .o_pre_ready  (o_pre_ready),
        .i_row_data   (i_row_data),
        .o_post_valid (o_post_valid),
        .i_post_ready (i_post_ready),
        .i_addr       (i_addr),
        .o_data       (o_data),
        .i_release    (i_release),
        .o_busy       (o_busy)
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            k;
        int            col;
        pixel_t        exp;
    } vec_t;

    vec_t tbl [10];

    // Reference model: a FIFO of up to two complete frames plus a staging
    // area for the frame being loaded.
    row_t fifo_mem [2][IMG_H];
    row_t stage    [IMG_H];
    int   m_head, m_count, m_rows;
    bit   m_busy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_win(input string nm, input win_t act, input win_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic row_t ramp_row(input int r);
        row_t x;
        for (int c = 0; c < IMG_W; c++) x[c] = pixel_t'((r + c) % 256);
        return x;
    endfunction

    function automatic row_t fill_row(input pixel_t f);
        row_t x;
        for (int c = 0; c < IMG_W; c++) x[c] = f;
        return x;
    endfunction

    // Present nbeats rows (ramp pattern when ramp=1, else constant f).
    task automatic load_rows(input bit ramp, input pixel_t f, input int nbeats);
        for (int r = 0; r < nbeats; r++) begin
            int n = 0;
            i_pre_valid = 1'b0;
            while (!o_pre_ready && n < 40) begin
                tick();
                n++;
            end
            if (!o_pre_ready) begin
                total++;
                bad++;
                $display("FAIL load_wait: got pre_ready=0 want 1 within 40 cycles");
            end
            i_pre_valid = 1'b1;
            i_row_data  = ramp ? ramp_row(r) : fill_row(f);
            tick();
        end
        i_pre_valid = 1'b0;
    endtask

    task automatic handshake();
        i_post_ready = 1'b1;
        tick();
        i_post_ready = 1'b0;
    endtask

    task automatic release_frame();
        i_release = 1'b1;
        tick();
        i_release = 1'b0;
    endtask

    task automatic run_table();
        for (int i = 0; i < 10; i++) begin
            i_addr = tbl[i].addr;
            #1;
            chk($sformatf("tbl%0d_a%0d_k%0d_c%0d", i, tbl[i].addr, tbl[i].k, tbl[i].col),
                32'(o_data[tbl[i].k][tbl[i].col]), 32'(tbl[i].exp));
        end
    endtask

    function automatic win_t model_win(input logic [AW-1:0] a);
        win_t w = '0;
        if (m_busy) begin
            for (int k = 0; k < K; k++) begin
                int r = int'(a) + k;
                if (r < IMG_H) w[k] = fifo_mem[m_head][r];
            end
        end
        return w;
    endfunction

    task automatic model_step();
        bit acc = i_pre_valid && (m_count < 2);
        bit hs  = !m_busy && (m_count > 0) && i_post_ready;
        bit rel = m_busy && i_release;
        if (acc) begin
            stage[m_rows] = i_row_data;
            m_rows++;
            if (m_rows == IMG_H) begin
                for (int r = 0; r < IMG_H; r++) fifo_mem[(m_head + m_count) % 2][r] = stage[r];
                m_count++;
                m_rows = 0;
            end
        end
        if (rel) begin
            m_head  = (m_head + 1) % 2;
            m_count--;
            m_busy  = 1'b0;
        end
        if (hs) m_busy = 1'b1;
    endtask

    initial begin
        tbl[0] = '{5'd0,  0, 5,  8'd5};
        tbl[1] = '{5'd0,  2, 27, 8'd29};
        tbl[2] = '{5'd25, 2, 0,  8'd27};
        tbl[3] = '{5'd25, 0, 3,  8'd28};
        tbl[4] = '{5'd26, 1, 27, 8'd54};
        tbl[5] = '{5'd26, 2, 0,  8'd0};
        tbl[6] = '{5'd31, 0, 0,  8'd0};
        tbl[7] = '{5'd31, 2, 27, 8'd0};
        tbl[8] = '{5'd13, 1, 10, 8'd24};
        tbl[9] = '{5'd27, 0, 27, 8'd54};

        // Reset state
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_pre_ready", 32'(o_pre_ready), 32'd1);
        chk("rst_post_valid", 32'(o_post_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk_win("rst_data", o_data, '0);
        i_rst = 1'b1;
        tick();

        // Single ramp frame, hand-off, table of window reads
        load_rows(1'b1, 8'h00, IMG_H);
        chk("sf_post_valid", 32'(o_post_valid), 32'd1);
        chk("sf_pre_ready", 32'(o_pre_ready), 32'd1);
        handshake();
        chk("sf_busy", 32'(o_busy), 32'd1);
        chk("sf_post_valid_low", 32'(o_post_valid), 32'd0);
        run_table();
        i_addr = 5'd26;
        #1 chk("bnd26_row2", 32'(o_data[2] == '0), 32'd1);
        i_addr = 5'd31;
        #1 chk_win("bnd31_all", o_data, '0);
        release_frame();
        chk("sf_rel_busy", 32'(o_busy), 32'd0);
        chk("sf_rel_post_valid", 32'(o_post_valid), 32'd0);
        chk_win("sf_idle_data", o_data, '0);

        // Ping-pong: A=0xAA handed off, B=0xBB loads while A is served
        load_rows(1'b0, 8'hAA, IMG_H);
        handshake();
        load_rows(1'b0, 8'hBB, IMG_H);
        chk("pp_both_full_ready", 32'(o_pre_ready), 32'd0);
        chk("pp_busy_post_valid", 32'(o_post_valid), 32'd0);
        i_addr = 5'd0;
        #1 chk("pp_read_a", 32'(o_data[1][7]), 32'hAA);
        release_frame();
        chk("pp_rel_ready", 32'(o_pre_ready), 32'd1);
        chk("pp_rel_post_valid", 32'(o_post_valid), 32'd1);
        chk("pp_rel_busy", 32'(o_busy), 32'd0);
        handshake();
        i_addr = 5'd10;
        #1 chk("pp_read_b", 32'(o_data[2][3]), 32'hBB);
        release_frame();

        // Final beat of B coincides with the release of A
        load_rows(1'b0, 8'h11, IMG_H);
        handshake();
        load_rows(1'b0, 8'h22, IMG_H - 1);
        i_pre_valid = 1'b1;
        i_row_data  = fill_row(8'h22);
        i_release   = 1'b1;
        tick();
        i_pre_valid = 1'b0;
        i_release   = 1'b0;
        chk("sim_pre_ready", 32'(o_pre_ready), 32'd1);
        chk("sim_post_valid", 32'(o_post_valid), 32'd1);
        chk("sim_busy", 32'(o_busy), 32'd0);
        handshake();
        i_addr = 5'd25;
        #1 chk("sim_read_b", 32'(o_data[2][27]), 32'h22);
        release_frame();

        // Backpressure on the hand-off and a release while idle
        load_rows(1'b0, 8'h33, IMG_H);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_hold%0d", i), 32'(o_post_valid), 32'd1);
            tick();
        end
        release_frame();
        chk("idle_rel_post_valid", 32'(o_post_valid), 32'd1);
        chk("idle_rel_busy", 32'(o_busy), 32'd0);
        chk("idle_rel_ready", 32'(o_pre_ready), 32'd1);
        handshake();
        i_addr = 5'd0;
        #1 chk("bp_read_c", 32'(o_data[0][0]), 32'h33);
        release_frame();

        // Reset while a frame is served and another is half loaded
        load_rows(1'b0, 8'h55, IMG_H);
        handshake();
        load_rows(1'b0, 8'h44, 14);
        i_rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(o_pre_ready), 32'd1);
        chk("mid_rst_post_valid", 32'(o_post_valid), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk_win("mid_rst_data", o_data, '0);
        i_rst = 1'b1;
        tick();
        load_rows(1'b1, 8'h00, IMG_H);
        chk("post_rst_post_valid", 32'(o_post_valid), 32'd1);
        handshake();
        run_table();
        release_frame();

        // Randomized traffic against the reference model
        i_rst = 1'b0;
        #1 i_rst = 1'b1;
        m_head = 0; m_count = 0; m_rows = 0; m_busy = 1'b0;
        tick();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            i_pre_valid  = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < IMG_W; c++) i_row_data[c] = pixel_t'($urandom);
            i_post_ready = ($urandom_range(0, 3) == 0);
            i_release    = m_busy ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 15) == 0);
            i_addr       = AW'($urandom_range(0, 31));
            #1;
            chk("rnd_pre_ready", 32'(o_pre_ready), 32'(m_count < 2));
            chk("rnd_post_valid", 32'(o_post_valid), 32'(!m_busy && m_count > 0));
            chk("rnd_busy", 32'(o_busy), 32'(m_busy));
            chk_win("rnd_data", o_data, model_win(i_addr));
            @(posedge i_clk);
            model_step();
            #1;
        end
        i_pre_valid  = 1'b0;
        i_post_ready = 1'b0;
        i_release    = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
